note_slot_pool: RTL and testbench
=================================

# note_slot_pool

- Parametrised per-lane note slot allocator and mover for the rhythm-game datapath.
- Sits between the chart/spawn logic and the note sprite renderer.
- Accepts lane-coded spawn requests from several ports and allocates each to the first free slot in its lane.
- Scrolls every live note down one step per frame tick, retires notes on a player hit or when they pass the strike line, and reports hits, misses and dropped spawns.

## Interface

Parameters:
- LANES, 5, number of note lanes
- SLOTS, 2, simultaneous notes per lane
- SPAWN_PORTS, 2, independent spawn request ports
- LANE_W, 3, width of one spawn code; must hold LANES (code 0 = no spawn, 1..LANES = lane 0..LANES-1)
- Y_W, 10, width of a note's vertical position
- Y_STEP, 2, pixels advanced per frame tick
- HIT_LO, 400, first y inside the hit window
- Y_END, 460, y at or beyond which an unhit note is missed

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- spawn_code  in  SPAWN_PORTS*LANE_W  packed spawn codes; port p occupies bits [p*LANE_W +: LANE_W]
- hit  in  LANES  one-cycle per-lane player strike pulses
- note_on  out  LANES*SLOTS  slot valid; bit index lane*SLOTS+slot
- note_y  out  LANES*SLOTS*Y_W  slot y positions, same ordering
- hit_ok  out  LANES  one-cycle pulse: strike retired a note
- miss  out  LANES  one-cycle pulse: a note passed Y_END unhit
- drop_count  out  8  saturating count of spawns lost to a full lane

## Operation

- State is per slot: a valid bit and a Y_W-bit y register.
- Spawn codes: 0 means no spawn; codes greater than LANES are ignored and are not counted as drops.
- Spawn allocation, per lane and per cycle:
  - Requests are served in ascending port order.
  - Each request takes the lowest-index slot that is invalid at the start of the cycle and not already taken by a lower-numbered port in the same cycle.
  - Two ports naming the same lane fill two distinct slots.
  - A request that finds no slot increments drop_count by 1.
  - Several drops in one cycle add their total, saturating at 255.
- A new note starts at y = 0. It is not advanced by a frame_tick in the same cycle.
- A slot freed in a cycle (by hit or miss) is not reusable until the next cycle.
- Strike (hit[l] = 1):
  - Eligible notes are valid slots in lane l with HIT_LO <= y < Y_END, using pre-tick y.
  - The slot with the largest y is cleared; ties go to the lowest index.
  - hit_ok[l] pulses.
  - If no note is eligible, nothing changes and hit_ok[l] stays 0.
- Frame tick:
  - Every valid slot not cleared by a hit this cycle gets y <= y + Y_STEP, computed at Y_W+1 bits so it cannot wrap.
  - If the result is >= Y_END, the slot is cleared instead of stored and miss[l] pulses.
  - Several misses in one lane in one cycle produce a single miss pulse.
- If a hit and a tick-miss target the same note in the same cycle, the hit wins and there is no miss.

## Timing

- All outputs are registered.
- Reset value of every output is 0: all note_on and note_y bits, hit_ok, miss and drop_count. All internal slots are cleared.
- Reset has priority over spawn, hit and tick in the same cycle. A note pool mid-scroll is discarded entirely.
- Latency is one cycle everywhere:
  - A spawn at edge N shows in note_on/note_y after edge N.
  - hit_ok and miss assert in the cycle after the causing edge and last exactly one cycle.
  - drop_count updates one cycle after the dropped request.
- There is no handshake and no backpressure. Spawns into a full lane are lost and counted.
- frame_tick may be high in consecutive cycles; each high cycle is one step.

## Configuration

- Macro: NOTE_POOL_DROP_CNT_EN.
- Defined: the 8-bit saturating drop counter is built as described above.
- Not defined: no counter register is built. drop_count is tied to 0 and full-lane spawns are silently discarded. All other behaviour is unchanged.

## Test plan

- Reset, then spawn_code port0 = 1 for one cycle:
  - next cycle note_on[0] = 1 and note_y slot0 = 0;
  - all other outputs are 0.
- Ports 0 and 1 both = 3 with lane 2 empty:
  - note_on[4] and note_on[5] both set next cycle.
  - Repeat with lane 2 full: drop_count goes 0 -> 2. 128 such cycles leave it saturated at 255.
- Single note in lane 0 with 230 ticks at Y_STEP = 2:
  - y reaches 460 on the 230th tick;
  - slot clears and miss[0] pulses for exactly one cycle.
- Lane 1 notes at y = 410 and y = 420, hit[1] pulsed:
  - the y = 420 slot clears, hit_ok[1] pulses, and the y = 410 note remains.
  - hit[1] with both notes at y < 400: no change, hit_ok[1] = 0.
- Note at y = 458, hit[4] and frame_tick in the same cycle:
  - note cleared, hit_ok[4] = 1, miss[4] = 0.
- Reset asserted together with spawn, hit and tick while 6 notes are live:
  - next cycle every output is 0 and no slot is valid.

Source files
------------

// File: rtl/note_slot_pool_if.sv
// Spawn/strike/tick inputs and registered slot-state outputs of note_slot_pool.
// master = chart/spawn side driving requests, slave = the slot pool.
interface note_slot_pool_if #(
  parameter int LANES       = 5,
  parameter int SLOTS       = 2,
  parameter int SPAWN_PORTS = 2,
  parameter int LANE_W      = 3,
  parameter int Y_W         = 10
);
  logic                          frame_tick;
  logic [SPAWN_PORTS*LANE_W-1:0] spawn_code;
  logic [LANES-1:0]              hit;
  logic [LANES*SLOTS-1:0]        note_on;
  logic [LANES*SLOTS*Y_W-1:0]    note_y;
  logic [LANES-1:0]              hit_ok;
  logic [LANES-1:0]              miss;
  logic [7:0]                    drop_count;

  modport master (
    output frame_tick, spawn_code, hit,
    input  note_on, note_y, hit_ok, miss, drop_count
  );

  modport slave (
    input  frame_tick, spawn_code, hit,
    output note_on, note_y, hit_ok, miss, drop_count
  );
endinterface

// File: rtl/note_slot_pool.sv
// Per-lane note slot allocator/scroller: spawns, strikes, frame-tick scrolling and misses.
// Optional macro NOTE_POOL_DROP_CNT_EN builds the 8-bit saturating dropped-spawn counter.
module note_slot_pool #(
  parameter int LANES       = 5,
  parameter int SLOTS       = 2,
  parameter int SPAWN_PORTS = 2,
  parameter int LANE_W      = 3,
  parameter int Y_W         = 10,
  parameter int Y_STEP      = 2,
  parameter int HIT_LO      = 400,
  parameter int Y_END       = 460
) (
  input logic             Clk,
  input logic             Reset,
  note_slot_pool_if.slave bus
);
  localparam int N = LANES * SLOTS;
  localparam logic [Y_W:0]   STEP_EXT = (Y_W+1)'(Y_STEP);
  localparam logic [Y_W:0]   END_EXT  = (Y_W+1)'(Y_END);
  localparam logic [Y_W-1:0] HIT_LO_Y = Y_W'(HIT_LO);
  localparam logic [Y_W-1:0] END_Y    = Y_W'(Y_END);

  logic [N-1:0]           r_valid;
  logic [N-1:0][Y_W-1:0]  r_y;
  logic [LANES-1:0]       r_hit_ok;
  logic [LANES-1:0]       r_miss;

  logic [N-1:0]           w_valid_nxt;
  logic [N-1:0][Y_W-1:0]  w_y_nxt;
  logic [LANES-1:0]       w_hit_ok_nxt;
  logic [LANES-1:0]       w_miss_nxt;

`ifdef NOTE_POOL_DROP_CNT_EN
  logic [7:0] r_drop_count;
  logic [7:0] w_drop_nxt;
`endif

  always_comb begin : next_state
    int             i;
    logic           hit_found;
    int             hit_idx;
    logic [Y_W-1:0] hit_y;
    logic [Y_W:0]   y_sum;
    logic           placed;
    logic [N-1:0]   taken;
`ifdef NOTE_POOL_DROP_CNT_EN
    int             drops;
    logic [8:0]     drop_sum;
`endif
    // NOTE: every comb-assigned variable gets a default up front so no latch is inferred.
    w_valid_nxt  = r_valid;
    w_y_nxt      = r_y;
    w_hit_ok_nxt = '0;
    w_miss_nxt   = '0;
    i            = 0;
    hit_found    = 1'b0;
    hit_idx      = 0;
    hit_y        = '0;
    y_sum        = '0;
    placed       = 1'b0;
    taken        = '0;
`ifdef NOTE_POOL_DROP_CNT_EN
    drops        = 0;
    drop_sum     = '0;
    w_drop_nxt   = r_drop_count;
`endif

    for (int l = 0; l < LANES; l++) begin
      // Strike picks the deepest in-window note; strict '>' keeps the lowest index on ties.
      hit_found = 1'b0;
      hit_idx   = 0;
      hit_y     = '0;
      for (int s = 0; s < SLOTS; s++) begin
        i = l * SLOTS + s;
        if (bus.hit[l] && r_valid[i] && r_y[i] >= HIT_LO_Y && r_y[i] < END_Y &&
            (!hit_found || r_y[i] > hit_y)) begin
          hit_found = 1'b1;
          hit_idx   = i;
          hit_y     = r_y[i];
        end
      end
      if (hit_found) w_hit_ok_nxt[l] = 1'b1;

      for (int s = 0; s < SLOTS; s++) begin
        i = l * SLOTS + s;
        if (hit_found && i == hit_idx) begin
          w_valid_nxt[i] = 1'b0;
        end else if (bus.frame_tick && r_valid[i]) begin
          y_sum = {1'b0, r_y[i]} + STEP_EXT;
          if (y_sum >= END_EXT) begin
            w_valid_nxt[i] = 1'b0;
            w_miss_nxt[l]  = 1'b1;
          end else begin
            w_y_nxt[i] = y_sum[Y_W-1:0];
          end
        end
      end

      // Allocation looks only at start-of-cycle validity, so slots freed above stay free this cycle.
      for (int p = 0; p < SPAWN_PORTS; p++) begin
        if (bus.spawn_code[p*LANE_W +: LANE_W] == LANE_W'(l + 1)) begin
          placed = 1'b0;
          for (int s = 0; s < SLOTS; s++) begin
            i = l * SLOTS + s;
            if (!placed && !r_valid[i] && !taken[i]) begin
              taken[i]       = 1'b1;
              placed         = 1'b1;
              w_valid_nxt[i] = 1'b1;
              w_y_nxt[i]     = '0;
            end
          end
`ifdef NOTE_POOL_DROP_CNT_EN
          if (!placed) drops = drops + 1;
`endif
        end
      end
    end

`ifdef NOTE_POOL_DROP_CNT_EN
    drop_sum   = {1'b0, r_drop_count} + 9'(drops);
    w_drop_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];
`endif
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments only; y registers are reset too
    // because they drive note_y directly and must read 0 after reset.
    if (Reset) begin
      r_valid  <= '0;
      r_y      <= '0;
      r_hit_ok <= '0;
      r_miss   <= '0;
    end else begin
      r_valid  <= w_valid_nxt;
      r_y      <= w_y_nxt;
      r_hit_ok <= w_hit_ok_nxt;
      r_miss   <= w_miss_nxt;
    end
  end

`ifdef NOTE_POOL_DROP_CNT_EN
  always_ff @(posedge Clk) begin
    if (Reset) r_drop_count <= '0;
    else       r_drop_count <= w_drop_nxt;
  end
  assign bus.drop_count = r_drop_count;
`else
  assign bus.drop_count = '0;
`endif

  assign bus.note_on = r_valid;
  assign bus.note_y  = r_y;
  assign bus.hit_ok  = r_hit_ok;
  assign bus.miss    = r_miss;
endmodule

// File: tb/tb_note_slot_pool.sv
// Directed bench for note_slot_pool: table-driven spawn/tick/strike vectors plus
// hand-written miss, strike-window, hit-vs-miss, drop-saturation and reset sequences.
`timescale 1ns/1ps
module tb_note_slot_pool;
  localparam int LANES = 5, SLOTS = 2, SPAWN_PORTS = 2, LANE_W = 3, Y_W = 10;
`ifdef NOTE_POOL_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  note_slot_pool_if #(.LANES(LANES), .SLOTS(SLOTS), .SPAWN_PORTS(SPAWN_PORTS),
                      .LANE_W(LANE_W), .Y_W(Y_W)) bus ();

  note_slot_pool #(.LANES(LANES), .SLOTS(SLOTS), .SPAWN_PORTS(SPAWN_PORTS),
                   .LANE_W(LANE_W), .Y_W(Y_W), .Y_STEP(2), .HIT_LO(400), .Y_END(460))
    dut (.Clk(clk), .Reset(rst), .bus(bus));

  typedef struct {
    logic [5:0] sp;
    logic [4:0] hit;
    logic       tick;
    int         slot;
    logic [9:0] on;
    logic [9:0] y;
    logic [4:0] hok;
    logic [4:0] miss;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [Y_W-1:0] slot_y(input int i);
    return bus.note_y[i*Y_W +: Y_W];
  endfunction

  function automatic logic [7:0] exp_drop(input int v);
    return DROP_EN ? 8'(v) : 8'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.spawn_code = '0;
    bus.hit        = '0;
    bus.frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic spawn(input logic [5:0] code);
    bus.spawn_code = code;
    step();
    bus.spawn_code = '0;
  endtask

  task automatic ticks(input int n);
    bus.frame_tick = 1'b1;
    repeat (n) step();
    bus.frame_tick = 1'b0;
  endtask

  initial begin
    // spawn codes written in octal: high digit = port1, low digit = port0
    tbl[0] = '{6'o01, 5'b00000, 1'b0, 0, 10'h001, 10'd0, 5'b0, 5'b0};
    tbl[1] = '{6'o33, 5'b00000, 1'b0, 4, 10'h031, 10'd0, 5'b0, 5'b0};
    tbl[2] = '{6'o00, 5'b00000, 1'b1, 0, 10'h031, 10'd2, 5'b0, 5'b0};
    tbl[3] = '{6'o20, 5'b00000, 1'b1, 2, 10'h035, 10'd0, 5'b0, 5'b0};
    tbl[4] = '{6'o00, 5'b00000, 1'b1, 2, 10'h035, 10'd2, 5'b0, 5'b0};
    tbl[5] = '{6'o67, 5'b00000, 1'b0, 0, 10'h035, 10'd6, 5'b0, 5'b0};
    tbl[6] = '{6'o00, 5'b00001, 1'b0, 0, 10'h035, 10'd6, 5'b0, 5'b0};
    tbl[7] = '{6'o04, 5'b00000, 1'b0, 6, 10'h075, 10'd0, 5'b0, 5'b0};
    tbl[8] = '{6'o11, 5'b00000, 1'b0, 1, 10'h077, 10'd0, 5'b0, 5'b0};

    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check("reset note_on", 128'(bus.note_on), 128'd0);
    check("reset note_y", 128'(bus.note_y), 128'd0);
    check("reset hit_ok", 128'(bus.hit_ok), 128'd0);
    check("reset miss", 128'(bus.miss), 128'd0);
    check("reset drop_count", 128'(bus.drop_count), 128'd0);
    rst = 1'b0;

    for (int k = 0; k < 9; k++) begin
      bus.spawn_code = tbl[k].sp;
      bus.hit        = tbl[k].hit;
      bus.frame_tick = tbl[k].tick;
      step();
      idle_inputs();
      check($sformatf("vec%0d note_on", k), 128'(bus.note_on), 128'(tbl[k].on));
      check($sformatf("vec%0d y[%0d]", k, tbl[k].slot), 128'(slot_y(tbl[k].slot)), 128'(tbl[k].y));
      check($sformatf("vec%0d hit_ok", k), 128'(bus.hit_ok), 128'(tbl[k].hok));
      check($sformatf("vec%0d miss", k), 128'(bus.miss), 128'(tbl[k].miss));
    end
    check("table drop_count", 128'(bus.drop_count), 128'(exp_drop(1)));

    // drop counting and saturation on a full lane 2
    do_reset();
    spawn(6'o33);
    check("fill lane2 drop", 128'(bus.drop_count), 128'd0);
    spawn(6'o33);
    check("double drop", 128'(bus.drop_count), 128'(exp_drop(2)));
    bus.spawn_code = 6'o33;
    repeat (127) step();
    idle_inputs();
    check("drop saturate", 128'(bus.drop_count), 128'(exp_drop(255)));
    check("lane2 still full", 128'(bus.note_on), 128'h030);

    // lane 0 note scrolls to the strike line and misses on the 230th tick
    do_reset();
    spawn(6'o01);
    ticks(229);
    check("pre-miss y", 128'(slot_y(0)), 128'd458);
    check("pre-miss on", 128'(bus.note_on), 128'h001);
    check("pre-miss no miss", 128'(bus.miss), 128'd0);
    ticks(1);
    check("miss clears", 128'(bus.note_on), 128'd0);
    check("miss pulse", 128'(bus.miss), 128'b00001);
    step();
    check("miss one cycle", 128'(bus.miss), 128'd0);

    // lane 1 strikes: out of window first, then deepest note retired
    do_reset();
    spawn(6'o02);
    ticks(5);
    spawn(6'o02);
    bus.hit = 5'b00010;
    step();
    idle_inputs();
    check("early hit on", 128'(bus.note_on), 128'h00C);
    check("early hit_ok", 128'(bus.hit_ok), 128'd0);
    check("early hit y2", 128'(slot_y(2)), 128'd10);
    ticks(205);
    check("lane1 y2", 128'(slot_y(2)), 128'd420);
    check("lane1 y3", 128'(slot_y(3)), 128'd410);
    bus.hit = 5'b00010;
    step();
    idle_inputs();
    check("hit on", 128'(bus.note_on), 128'h008);
    check("hit keeps y3", 128'(slot_y(3)), 128'd410);
    check("hit_ok pulse", 128'(bus.hit_ok), 128'b00010);
    step();
    check("hit_ok one cycle", 128'(bus.hit_ok), 128'd0);

    // hit wins over a same-cycle tick miss in lane 4
    do_reset();
    spawn(6'o05);
    ticks(229);
    check("lane4 y", 128'(slot_y(8)), 128'd458);
    bus.hit        = 5'b10000;
    bus.frame_tick = 1'b1;
    step();
    idle_inputs();
    check("hit+tick on", 128'(bus.note_on), 128'd0);
    check("hit+tick hit_ok", 128'(bus.hit_ok), 128'b10000);
    check("hit+tick miss", 128'(bus.miss), 128'd0);

    // reset beats spawn/hit/tick with six live notes
    do_reset();
    spawn(6'o11);
    spawn(6'o22);
    spawn(6'o33);
    ticks(3);
    check("six live", 128'(bus.note_on), 128'h03F);
    bus.spawn_code = 6'o44;
    bus.hit        = 5'b11111;
    bus.frame_tick = 1'b1;
    rst            = 1'b1;
    step();
    check("rst on", 128'(bus.note_on), 128'd0);
    check("rst y", 128'(bus.note_y), 128'd0);
    check("rst hit_ok", 128'(bus.hit_ok), 128'd0);
    check("rst miss", 128'(bus.miss), 128'd0);
    check("rst drop", 128'(bus.drop_count), 128'd0);
    rst = 1'b0;
    idle_inputs();
    step();
    check("post-rst empty", 128'(bus.note_on), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
